arf_sequencer: RTL and testbench
================================

Name: arf_sequencer

Overview:
Micro-sequencer for the address register file (PC, SP, AR). Accepts one stack or program-flow command at a time over a valid/ready handshake. Expands each command into a fixed sequence of RegSel/FunSel/OutCSel/OutDSel control words plus memory strobes, one step per clock. Sits between the instruction decoder and the address register file / memory port. Detects stack overflow and underflow from the live SP value.

Parameters:
STACK_EMPTY, 16'h0400, SP value when the stack holds nothing; POP/RET at this value faults.
STACK_FULL, 16'h0300, lowest legal SP; PUSH/CALL at this value faults.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high; forces IDLE
CmdValid  input  1  command request
Cmd  input  3  command code, sampled only on acceptance
CmdReady  output  1  high only in IDLE
SPValue  input  16  current SP contents from the register file
RegSel  output  3  register enables: bit2 PC, bit1 SP, bit0 AR
FunSel  output  2  00 decrement, 01 increment, 10 load, 11 clear
OutCSel  output  2  00 PC, 01 SP, 1x AR (data path)
OutDSel  output  2  00 PC, 01 SP, 1x AR (memory address)
ISel  output  1  register load source: 0 external operand, 1 memory read data
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
Done  output  1  one-cycle pulse on the final step of a command
Fault  output  1  one-cycle pulse when a command is rejected for stack bounds

Behaviour:
- Idle defaults: RegSel=000, FunSel=00, OutCSel=00, OutDSel=00, ISel=0, MemRead=0, MemWrite=0, Done=0, Fault=0, CmdReady=1. These are also the reset values of all outputs.
- Outputs are a combinational decode of the registered state. Any step not listed drives its field at the idle default.
- Acceptance: on the rising edge where CmdValid&&CmdReady, Cmd is latched and step 1 starts the next cycle.
- Cmd and CmdValid are ignored while busy.
- CmdReady returns high in the cycle after Done, so there is a minimum one-cycle bubble between commands.
- Command sequences (one line per step; each step is one cycle):
  - 000 NOP: S1 all defaults, Done.
  - 001 FETCH: S1 OutDSel=00, MemRead. S2 RegSel=100, FunSel=01 (PC++), Done.
  - 010 PUSH: S1 RegSel=010, FunSel=00 (SP--). S2 OutDSel=01, OutCSel=10, MemWrite, Done.
  - 011 POP: S1 OutDSel=01, MemRead. S2 RegSel=010, FunSel=01 (SP++), Done.
  - 100 LOAD_PC: S1 RegSel=100, FunSel=10, ISel=0, Done.
  - 101 CALL: S1 SP--. S2 OutDSel=01, OutCSel=00, MemWrite. S3 RegSel=100, FunSel=10, ISel=0, Done.
  - 110 RET: S1 OutDSel=01, MemRead. S2 RegSel=100, FunSel=10, ISel=1. S3 SP++, Done.
  - 111 LOAD_SP: S1 RegSel=010, FunSel=10, ISel=0, Done.
- Bounds check: evaluated in the first step cycle using SPValue.
  - PUSH/CALL with SPValue==STACK_FULL, or POP/RET with SPValue==STACK_EMPTY: that cycle becomes a FAULT step.
  - FAULT step: all register enables 0, no memory strobes, Fault=1, Done=1. No further steps.
  - LOAD_SP is never checked.
- Only one register enable bit is ever high in a cycle; FunSel is meaningful only when RegSel!=000.
- MemRead and MemWrite are never high together.
- Reset asserted mid-sequence: state goes to IDLE immediately and asynchronously, outputs go to defaults, and the latched command is discarded. Partial register updates are not rolled back.
- State machine: IDLE -> S1 -> S2 -> S3 -> IDLE, with early return after the command's last step. FAULT is a replacement for S1 and returns to IDLE.

Test Plan:
- Reset, then FETCH -> cycle+1: OutDSel=00, MemRead=1. Cycle+2: RegSel=100, FunSel=01, Done=1. Cycle+3: CmdReady=1.
- LOAD_SP with operand 16'h0400, then PUSH with SPValue=16'h0400 -> S1 RegSel=010, FunSel=00. S2 OutDSel=01, OutCSel=10, MemWrite=1, Done=1. Fault stays 0.
- CALL with SPValue=16'h03FF -> three steps (SP--, write PC at SP, PC load ISel=0). Done is high only in step 3, and MemWrite only in step 2.
- RET with SPValue=16'h0400 (==STACK_EMPTY) -> one cycle with Fault=1, Done=1, RegSel=000, MemRead=0. CmdReady=1 in the following cycle.
- PUSH with SPValue=16'h0300 -> Fault; POP with SPValue=16'h03FE -> normal two-step POP.
- Assert Reset during RET step 2 -> outputs at defaults in the same cycle. After release, CmdReady=1, and a new NOP completes with Done one cycle after acceptance.

Source files
------------

// File: rtl/arf_sequencer_if.sv
// Command handshake and register-file/memory control bundle for arf_sequencer.
// The master side is the decoder; the slave side is the sequencer.
interface arf_sequencer_if;
  logic        CmdValid;
  logic [2:0]  Cmd;
  logic        CmdReady;
  logic [15:0] SPValue;
  logic [2:0]  RegSel;
  logic [1:0]  FunSel;
  logic [1:0]  OutCSel;
  logic [1:0]  OutDSel;
  logic        ISel;
  logic        MemRead;
  logic        MemWrite;
  logic        Done;
  logic        Fault;

  modport master (
    output CmdValid, Cmd, SPValue,
    input  CmdReady, RegSel, FunSel, OutCSel, OutDSel, ISel, MemRead, MemWrite, Done, Fault
  );

  modport slave (
    input  CmdValid, Cmd, SPValue,
    output CmdReady, RegSel, FunSel, OutCSel, OutDSel, ISel, MemRead, MemWrite, Done, Fault
  );
endinterface

// File: rtl/arf_sequencer.sv
// Address register file micro-sequencer: expands one stack/flow command into
// per-cycle RegSel/FunSel/OutCSel/OutDSel words and memory strobes.
module arf_sequencer #(
  parameter logic [15:0] STACK_EMPTY = 16'h0400,
  parameter logic [15:0] STACK_FULL  = 16'h0300
) (
  input  logic           Clock,
  input  logic           Reset,
  arf_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;
  typedef enum logic [2:0] {
    C_NOP, C_FETCH, C_PUSH, C_POP, C_LOAD_PC, C_CALL, C_RET, C_LOAD_SP
  } cmd_t;

  localparam logic [2:0] R_NONE = 3'b000, R_PC = 3'b100, R_SP = 3'b010;
  localparam logic [1:0] F_DEC = 2'b00, F_INC = 2'b01, F_LOAD = 2'b10;
  localparam logic [1:0] SEL_PC = 2'b00, SEL_SP = 2'b01, SEL_AR = 2'b10;

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;

  logic [2:0] reg_sel;
  logic [1:0] fun_sel, outc_sel, outd_sel;
  logic       i_sel, mem_rd, mem_wr, done, fault, ready, last;
  logic       bounds_fault;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cmd_q   <= C_NOP;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Bounds are judged against the live SP in the first step, so a stale SP
  // at acceptance time cannot mask an overflow/underflow.
  always_comb begin
    bounds_fault = 1'b0;
    if (state_q == S1) begin
      unique case (cmd_q)
        C_PUSH, C_CALL: bounds_fault = (bus.SPValue == STACK_FULL);
        C_POP,  C_RET:  bounds_fault = (bus.SPValue == STACK_EMPTY);
        default:        bounds_fault = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    reg_sel  = R_NONE;
    fun_sel  = F_DEC;
    outc_sel = SEL_PC;
    outd_sel = SEL_PC;
    i_sel    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    fault    = 1'b0;
    ready    = 1'b0;
    last     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.CmdValid) begin
          cmd_d   = cmd_t'(bus.Cmd);
          state_d = S1;
        end
      end
      S1: begin
        if (bounds_fault) begin
          fault = 1'b1;
          last  = 1'b1;
        end else begin
          unique case (cmd_q)
            C_NOP:   last = 1'b1;
            C_FETCH: mem_rd = 1'b1;
            C_PUSH, C_CALL: begin
              reg_sel = R_SP;
              fun_sel = F_DEC;
            end
            C_POP, C_RET: begin
              outd_sel = SEL_SP;
              mem_rd   = 1'b1;
            end
            C_LOAD_PC: begin
              reg_sel = R_PC;
              fun_sel = F_LOAD;
              last    = 1'b1;
            end
            C_LOAD_SP: begin
              reg_sel = R_SP;
              fun_sel = F_LOAD;
              last    = 1'b1;
            end
            default: last = 1'b1;
          endcase
        end
      end
      S2: begin
        unique case (cmd_q)
          C_FETCH: begin
            reg_sel = R_PC;
            fun_sel = F_INC;
            last    = 1'b1;
          end
          C_PUSH: begin
            outd_sel = SEL_SP;
            outc_sel = SEL_AR;
            mem_wr   = 1'b1;
            last     = 1'b1;
          end
          C_POP: begin
            reg_sel = R_SP;
            fun_sel = F_INC;
            last    = 1'b1;
          end
          C_CALL: begin
            outd_sel = SEL_SP;
            outc_sel = SEL_PC;
            mem_wr   = 1'b1;
          end
          C_RET: begin
            reg_sel = R_PC;
            fun_sel = F_LOAD;
            i_sel   = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S3: begin
        last = 1'b1;
        unique case (cmd_q)
          C_CALL: begin
            reg_sel = R_PC;
            fun_sel = F_LOAD;
          end
          C_RET: begin
            reg_sel = R_SP;
            fun_sel = F_INC;
          end
          default: ;
        endcase
      end
      default: last = 1'b1;
    endcase

    done = last;
    if (state_q != IDLE) begin
      unique case (state_q)
        S1:      state_d = last ? IDLE : S2;
        S2:      state_d = last ? IDLE : S3;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.CmdReady = ready;
  assign bus.RegSel   = reg_sel;
  assign bus.FunSel   = fun_sel;
  assign bus.OutCSel  = outc_sel;
  assign bus.OutDSel  = outd_sel;
  assign bus.ISel     = i_sel;
  assign bus.MemRead  = mem_rd;
  assign bus.MemWrite = mem_wr;
  assign bus.Done     = done;
  assign bus.Fault    = fault;

endmodule

// File: tb/tb_arf_sequencer.sv
// Directed bench for arf_sequencer: each step's full control word is compared
// against a hand-written expected word.
module tb_arf_sequencer;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  arf_sequencer_if ifc();

  arf_sequencer dut (.Clock(Clock), .Reset(Reset), .bus(ifc.slave));

  always #5 Clock = ~Clock;

  // {RegSel,FunSel,OutCSel,OutDSel,ISel,MemRead,MemWrite,Done,Fault,CmdReady}
  function automatic logic [14:0] w(input logic [2:0] rs, input logic [1:0] fs,
                                    input logic [1:0] oc, input logic [1:0] od,
                                    input logic is, input logic mr, input logic mw,
                                    input logic dn, input logic ft, input logic rdy);
    return {rs, fs, oc, od, is, mr, mw, dn, ft, rdy};
  endfunction

  function automatic logic [14:0] obs();
    return {ifc.RegSel, ifc.FunSel, ifc.OutCSel, ifc.OutDSel, ifc.ISel,
            ifc.MemRead, ifc.MemWrite, ifc.Done, ifc.Fault, ifc.CmdReady};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a command in the bubble/idle cycle; it is accepted on the next edge.
  task automatic issue(input string tag, input logic [2:0] c, input logic [15:0] sp);
    @(negedge Clock);
    chk({tag, "_ready"}, 32'(ifc.CmdReady), 32'd1);
    ifc.CmdValid = 1'b1;
    ifc.Cmd      = c;
    ifc.SPValue  = sp;
    @(posedge Clock);
    #1;
    ifc.CmdValid = 1'b0;
    ifc.Cmd      = 3'b000;
  endtask

  task automatic step(input string tag, input logic [14:0] exp);
    @(negedge Clock);
    chk(tag, 32'(obs()), 32'(exp));
  endtask

  localparam logic [14:0] IDLEW = 15'b000_00_00_00_0_0_0_0_0_1;
  localparam logic [14:0] FLTW  = 15'b000_00_00_00_0_0_0_1_1_0;

  initial begin
    ifc.CmdValid = 1'b0;
    ifc.Cmd      = 3'b000;
    ifc.SPValue  = 16'h0400;
    #2;
    chk("reset_word", 32'(obs()), 32'(IDLEW));
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // FETCH
    issue("fetch", 3'b001, 16'h0400);
    step("fetch_s1", w(3'b000, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0));
    step("fetch_s2", w(3'b100, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    step("fetch_idle", IDLEW);

    // LOAD_SP then PUSH at the empty mark (legal)
    issue("ldsp", 3'b111, 16'h0400);
    step("ldsp_s1", w(3'b010, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    issue("push", 3'b010, 16'h0400);
    step("push_s1", w(3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    step("push_s2", w(3'b000, 2'b00, 2'b10, 2'b01, 0, 0, 1, 1, 0, 0));

    // CALL
    issue("call", 3'b101, 16'h03FF);
    step("call_s1", w(3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    step("call_s2", w(3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0));
    step("call_s3", w(3'b100, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));

    // RET on empty stack faults
    issue("ret_empty", 3'b110, 16'h0400);
    step("ret_empty_fault", FLTW);
    step("ret_empty_idle", IDLEW);

    // PUSH on full stack faults, POP near top is normal
    issue("push_full", 3'b010, 16'h0300);
    step("push_full_fault", FLTW);
    issue("pop", 3'b011, 16'h03FE);
    step("pop_s1", w(3'b000, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0));
    step("pop_s2", w(3'b010, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));

    // CALL on full stack faults; LOAD_SP at same value is never checked
    issue("call_full", 3'b101, 16'h0300);
    step("call_full_fault", FLTW);
    issue("ldsp_full", 3'b111, 16'h0300);
    step("ldsp_full_s1", w(3'b010, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    issue("ldpc", 3'b100, 16'h0300);
    step("ldpc_s1", w(3'b100, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));

    // Full RET, with a new command held valid while busy (must be ignored)
    issue("ret", 3'b110, 16'h03FE);
    ifc.CmdValid = 1'b1;
    ifc.Cmd      = 3'b100;
    step("ret_s1", w(3'b000, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0));
    step("ret_s2", w(3'b100, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
    step("ret_s3", w(3'b010, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    ifc.CmdValid = 1'b0;
    step("ret_idle", IDLEW);

    // Reset asserted during RET step 2
    issue("ret_rst", 3'b110, 16'h03FE);
    step("ret_rst_s1", w(3'b000, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0));
    step("ret_rst_s2", w(3'b100, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
    #1 Reset = 1'b1;
    #1 chk("ret_rst_async", 32'(obs()), 32'(IDLEW));
    @(negedge Clock);
    Reset = 1'b0;
    step("post_rst_idle", IDLEW);
    issue("nop", 3'b000, 16'h03FE);
    step("nop_s1", w(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
    step("nop_idle", IDLEW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
